seven_seg_capture: RTL and testbench

- Receive-side counterpart of the two-digit multiplexed seven-segment driver.
- Samples the time-multiplexed `segment` bus on each one-cycle `sig` strobe and tracks the hi/lo digit phase.
- Checks strobe spacing against the driver's refresh period and reconstructs the 14-bit pattern pair.
- Decodes both digits to hex nibbles; used in loopback self-test and by board-level monitors.

---
 rtl/seven_seg_pkg.sv | 30 +++
 rtl/seven_seg_decode.sv | 36 +++
 rtl/seven_seg_capture.sv | 143 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the two-digit seven-segment driver and capture blocks.
// Glyph encodings are bit0=a .. bit6=g, active-high.
package seven_seg_pkg;

    localparam int DEFAULT_FREQ = 17500;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        GOT_HI = 2'd1,
        GOT_LO = 2'd2
    } capture_state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational glyph-to-nibble decoder; anything outside the 16 hex glyphs
// (including blank) is flagged illegal and decodes to 0.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] segment,
    output logic [3:0] nibble,
    output logic       legal
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (segment)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed two-digit seven-segment link: samples the
// segment bus on each strobe, checks strobe spacing and rebuilds the digit pair.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int FREQ  = DEFAULT_FREQ,
    parameter int TOL   = 4,
    parameter int CBITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segment,
    input  logic        sig,
    output logic [13:0] raw,
    output logic [7:0]  value,
    output logic        pair_valid,
    output logic        locked,
    output logic        err_pattern,
    output logic        err_sync
);

    // gap_q counts idle cycles since the last strobe; elapsed is the strobe-to-strobe
    // distance, so a strobe exactly one refresh period later sees elapsed == FREQ+1.
    localparam logic [CBITS-1:0] GAP_SAT = CBITS'(FREQ + TOL + 2);
    localparam logic [CBITS:0]   WIN_LO  = (CBITS + 1)'(FREQ + 1 - TOL);
    localparam logic [CBITS:0]   WIN_HI  = (CBITS + 1)'(FREQ + 1 + TOL);
    localparam logic [CBITS:0]   TIMEOUT = (CBITS + 1)'(FREQ + TOL + 2);

    capture_state_e   state_q, state_d;
    logic [CBITS-1:0] gap_q, gap_d;
    logic [6:0]       hi_buf_q, hi_buf_d;
    logic             hi_ok_q, hi_ok_d;
    logic [13:0]      raw_q, raw_d;
    logic [7:0]       value_q, value_d;
    logic             pair_valid_q, pair_valid_d;
    logic             locked_q, locked_d;
    logic             err_pattern_q, err_pattern_d;
    logic             err_sync_q, err_sync_d;

    logic [CBITS:0]   elapsed;
    logic             early, late;
    logic [3:0]       lo_nib, hi_nib;
    logic             lo_legal, hi_legal;

    seven_seg_decode u_dec_lo (
        .segment (segment),
        .nibble  (lo_nib),
        .legal   (lo_legal)
    );

    seven_seg_decode u_dec_hi (
        .segment (hi_buf_q),
        .nibble  (hi_nib),
        .legal   (hi_legal)
    );

    assign elapsed = {1'b0, gap_q} + (CBITS + 1)'(1);
    assign early   = (elapsed < WIN_LO);
    assign late    = (elapsed > WIN_HI);

    always_comb begin
        state_d       = state_q;
        hi_buf_d      = hi_buf_q;
        hi_ok_d       = hi_ok_q;
        raw_d         = raw_q;
        value_d       = value_q;
        pair_valid_d  = 1'b0;
        err_pattern_d = 1'b0;
        err_sync_d    = 1'b0;

        if (sig) begin
            gap_d = '0;
        end else if (gap_q == GAP_SAT) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + CBITS'(1);
        end

        if (sig) begin
            if (state_q != HUNT && early) begin
                // Too-early strobe is dropped and the link is considered lost.
                err_sync_d = 1'b1;
                state_d    = HUNT;
            end else if (state_q == GOT_HI && !late) begin
                raw_d         = {hi_buf_q, segment};
                err_pattern_d = ~lo_legal;
                state_d       = GOT_LO;
                if (hi_ok_q && hi_legal && lo_legal) begin
                    value_d      = {hi_nib, lo_nib};
                    pair_valid_d = 1'b1;
                end
            end else begin
                // HUNT, in-window strobe after a lo digit, or a late strobe:
                // all of them start a new pair with this digit as hi.
                err_sync_d    = (state_q != HUNT) && late;
                hi_buf_d      = segment;
                hi_ok_d       = lo_legal;
                err_pattern_d = ~lo_legal;
                state_d       = GOT_HI;
            end
        end else if (state_q != HUNT && elapsed == TIMEOUT) begin
            err_sync_d = 1'b1;
            state_d    = HUNT;
        end

        locked_d = (state_d != HUNT);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            gap_q         <= '0;
            hi_buf_q      <= '0;
            hi_ok_q       <= 1'b0;
            raw_q         <= '0;
            value_q       <= '0;
            pair_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            err_pattern_q <= 1'b0;
            err_sync_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            hi_buf_q      <= hi_buf_d;
            hi_ok_q       <= hi_ok_d;
            raw_q         <= raw_d;
            value_q       <= value_d;
            pair_valid_q  <= pair_valid_d;
            locked_q      <= locked_d;
            err_pattern_q <= err_pattern_d;
            err_sync_q    <= err_sync_d;
        end
    end

    assign raw         = raw_q;
    assign value       = value_q;
    assign pair_valid  = pair_valid_q;
    assign locked      = locked_q;
    assign err_pattern = err_pattern_q;
    assign err_sync    = err_sync_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with FREQ=8 (period 9), TOL=1: a vector
// table of strobe gap/glyph/expected outputs plus hand-written timing sequences.
module tb_seven_seg_capture;

    localparam int FREQ  = 8;
    localparam int TOL   = 1;
    localparam int CBITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  segment;
    logic        sig;
    logic [13:0] raw;
    logic [7:0]  value;
    logic        pair_valid;
    logic        locked;
    logic        err_pattern;
    logic        err_sync;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          gap;
        logic [6:0]  seg;
        logic [13:0] raw;
        logic [7:0]  value;
        logic        pv;
        logic        locked;
        logic        ep;
        logic        es;
    } vec_t;

    vec_t       vecs [20];
    logic [6:0] glyph [16];

    seven_seg_capture #(.FREQ(FREQ), .TOL(TOL), .CBITS(CBITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .segment     (segment),
        .sig         (sig),
        .raw         (raw),
        .value       (value),
        .pair_valid  (pair_valid),
        .locked      (locked),
        .err_pattern (err_pattern),
        .err_sync    (err_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [13:0] e_raw, input logic [7:0] e_val,
                              input logic e_pv, input logic e_lk, input logic e_ep, input logic e_es);
        check({tag, ".raw"},         32'(raw),         32'(e_raw));
        check({tag, ".value"},       32'(value),       32'(e_val));
        check({tag, ".pair_valid"},  32'(pair_valid),  32'(e_pv));
        check({tag, ".locked"},      32'(locked),      32'(e_lk));
        check({tag, ".err_pattern"}, 32'(err_pattern), 32'(e_ep));
        check({tag, ".err_sync"},    32'(err_sync),    32'(e_es));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobe lands gap cycles after the previous one; outputs are sampled right after it.
    task automatic strobe(input int gap, input logic [6:0] seg);
        idle(gap - 1);
        sig     = 1'b1;
        segment = seg;
        @(posedge clk);
        #1;
        sig     = 1'b0;
        segment = 7'h00;
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        vecs[0]  = '{3,  7'h06, 14'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{9,  7'h5B, 14'h035B, 8'h12, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{9,  7'h7F, 14'h035B, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{9,  7'h71, 14'h3FF1, 8'h8F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{8,  7'h7F, 14'h3FF1, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{10, 7'h71, 14'h3FF1, 8'h8F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{9,  7'h7F, 14'h3FF1, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{9,  7'h71, 14'h3FF1, 8'h8F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{10, 7'h7F, 14'h3FF1, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8,  7'h71, 14'h3FF1, 8'h8F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{9,  7'h3F, 14'h3FF1, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{5,  7'h06, 14'h3FF1, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{9,  7'h06, 14'h3FF1, 8'h8F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{9,  7'h4F, 14'h034F, 8'h13, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{9,  7'h3F, 14'h034F, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{9,  7'h00, 14'h1F80, 8'h13, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{11, 7'h66, 14'h1F80, 8'h13, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{9,  7'h6D, 14'h336D, 8'h45, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{9,  7'h08, 14'h336D, 8'h45, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{9,  7'h06, 14'h0406, 8'h45, 1'b0, 1'b1, 1'b0, 1'b0};

        rst     = 1'b1;
        sig     = 1'b0;
        segment = 7'h00;
        idle(3);
        check_outs("reset", 14'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            strobe(vecs[i].gap, vecs[i].seg);
            check_outs($sformatf("vec%0d", i), vecs[i].raw, vecs[i].value,
                       vecs[i].pv, vecs[i].locked, vecs[i].ep, vecs[i].es);
        end

        // Walk every legal glyph through both digit positions.
        for (int i = 0; i < 8; i++) begin
            strobe(9, glyph[2*i]);
            strobe(9, glyph[2*i+1]);
            check_outs($sformatf("glyph%0d", i), {glyph[2*i], glyph[2*i+1]},
                       {4'(2*i), 4'(2*i+1)}, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Timeout: err_sync fires once, eleven cycles after the hi strobe.
        strobe(9, 7'h3F);
        for (int j = 1; j <= 13; j++) begin
            idle(1);
            check($sformatf("timeout%0d.err_sync", j), 32'(err_sync), 32'(j == 11));
            check($sformatf("timeout%0d.locked", j),   32'(locked),   32'(j < 11));
        end
        check("timeout.raw",   32'(raw),   32'(14'h3CF1));
        check("timeout.value", 32'(value), 32'(8'hEF));

        // Back-to-back strobes: second is early, third starts a new pair.
        strobe(3, 7'h06);
        check_outs("b2b.hi", 14'h3CF1, 8'hEF, 1'b0, 1'b1, 1'b0, 1'b0);
        strobe(1, 7'h5B);
        check_outs("b2b.early", 14'h3CF1, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1);
        strobe(1, 7'h4F);
        check_outs("b2b.rehi", 14'h3CF1, 8'hEF, 1'b0, 1'b1, 1'b0, 1'b0);
        strobe(9, 7'h06);
        check_outs("b2b.pair", 14'h2786, 8'h31, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("b2b.pulse_width", 32'(pair_valid), 32'(1'b0));

        // Reset coincident with an in-window lo strobe wins.
        strobe(9, 7'h7F);
        idle(8);
        rst     = 1'b1;
        sig     = 1'b1;
        segment = 7'h06;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        sig     = 1'b0;
        segment = 7'h00;
        check_outs("rst_mid", 14'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(3, 7'h5B);
        check_outs("rst_mid.hi", 14'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        strobe(9, 7'h06);
        check_outs("rst_mid.pair", 14'h2D86, 8'h21, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
